regfile_wb_queue: RTL and testbench

- Write-side front end for the register file.
- Accepts writeback requests (rd, data) over a valid/ready handshake and buffers them in an in-order FIFO.
- Drains one entry per cycle onto the register file write port (we3/a3/wd3) whenever that port is not busy.
- Provides newest-first forwarding of pending writes to the two read addresses (a1/a2), so decode never sees stale register data while writes are queued.

---
 rtl/riscy32_pkg.sv | 15 +
 rtl/wb_fwd_lookup.sv | 35 +++
 rtl/regfile_wb_queue.sv | 125 ++++++++++++
 tb/tb_regfile_wb_queue.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscy32_pkg.sv
// Shared register-file definitions: data/address widths, the x0 constant and
// the writeback request record carried by the write queue.
package riscy32_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fwd_lookup.sv
// Newest-first match of one read address against the pending write entries.
// Entries are scanned from wr_ptr-1 backwards; the first valid match wins.
module wb_fwd_lookup
    import riscy32_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] valid,
    input  logic [AW-1:0]    rd   [DEPTH],
    input  logic [XLEN-1:0]  data [DEPTH],
    input  logic [PW-1:0]    wr_ptr,
    input  logic [AW-1:0]    addr,
    output logic             hit,
    output logic [XLEN-1:0]  hit_data
);

    always_comb begin
        logic [PW-1:0] idx;
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        // i = DEPTH wraps back onto wr_ptr itself, the oldest slot when full.
        for (int i = 1; i <= DEPTH; i++) begin
            idx = wr_ptr - PW'(i);
            if (!hit && (addr != AW'(REG_ZERO)) && valid[idx] && (rd[idx] == addr)) begin
                hit      = 1'b1;
                hit_data = data[idx];
            end
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// Register-file write front end: in-order writeback FIFO draining onto the
// single write port, with newest-first forwarding to both read ports.
module regfile_wb_queue
    import riscy32_pkg::*;
#(
    parameter int XLEN  = riscy32_pkg::XLEN,
    parameter int AW    = riscy32_pkg::AW,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_rd,
    input  logic [XLEN-1:0] in_data,
    input  logic            wport_busy,
    output logic            we3,
    output logic [AW-1:0]   a3,
    output logic [XLEN-1:0] wd3,
    input  logic [AW-1:0]   a1,
    input  logic [AW-1:0]   a2,
    output logic            fwd1_hit,
    output logic [XLEN-1:0] fwd1_data,
    output logic            fwd2_hit,
    output logic [XLEN-1:0] fwd2_data,
    output logic [CW-1:0]   count,
    output logic            empty
);

    logic [AW-1:0]    rd_q   [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;

    logic             accept;
    logic             push;
    logic             pop;
    logic             hit1_raw;
    logic             hit2_raw;
    logic [XLEN-1:0]  data1_raw;
    logic [XLEN-1:0]  data2_raw;

    // Handshake and drain decisions come from registered occupancy only.
    assign in_ready = !rst && (count_q < CW'(DEPTH));
    assign empty    = rst || (count_q == '0);
    assign count    = count_q;

    assign accept = in_valid && in_ready;
    assign push   = accept && (in_rd != AW'(REG_ZERO));
    assign pop    = we3;

    assign we3 = !empty && !wport_busy && !rst;
    assign a3  = we3 ? rd_q[rd_ptr]   : '0;
    assign wd3 = we3 ? data_q[rd_ptr] : '0;

    // Control state: pointers, occupancy and per-entry valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (push) begin
                valid_q[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry payloads need no reset; valid_q qualifies them.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wr_ptr]   <= in_rd;
            data_q[wr_ptr] <= in_data;
        end
    end

    wb_fwd_lookup #(
        .XLEN  (XLEN),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_fwd1 (
        .valid    (valid_q),
        .rd       (rd_q),
        .data     (data_q),
        .wr_ptr   (wr_ptr),
        .addr     (a1),
        .hit      (hit1_raw),
        .hit_data (data1_raw)
    );

    wb_fwd_lookup #(
        .XLEN  (XLEN),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_fwd2 (
        .valid    (valid_q),
        .rd       (rd_q),
        .data     (data_q),
        .wr_ptr   (wr_ptr),
        .addr     (a2),
        .hit      (hit2_raw),
        .hit_data (data2_raw)
    );

    assign fwd1_hit  = rst ? 1'b0 : hit1_raw;
    assign fwd1_data = rst ? '0   : data1_raw;
    assign fwd2_hit  = rst ? 1'b0 : hit2_raw;
    assign fwd2_data = rst ? '0   : data2_raw;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue: directed plan steps followed by a
// randomized phase, all compared against a queue-based reference model.
module tb_regfile_wb_queue;
    import riscy32_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [AW-1:0]   in_rd;
    logic [XLEN-1:0] in_data;
    logic            wport_busy;
    logic            we3;
    logic [AW-1:0]   a3;
    logic [XLEN-1:0] wd3;
    logic [AW-1:0]   a1;
    logic [AW-1:0]   a2;
    logic            fwd1_hit;
    logic [XLEN-1:0] fwd1_data;
    logic            fwd2_hit;
    logic [XLEN-1:0] fwd2_data;
    logic [CW-1:0]   count;
    logic            empty;

    int checks = 0;
    int errors = 0;

    wb_req_t         q[$];
    logic [XLEN-1:0] rf_model [32];
    logic [XLEN-1:0] dut_rf   [32];
    bit              exp_we;
    bit              accepted;
    bit              last_acc;

    regfile_wb_queue #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd      (in_rd),
        .in_data    (in_data),
        .wport_busy (wport_busy),
        .we3        (we3),
        .a3         (a3),
        .wd3        (wd3),
        .a1         (a1),
        .a2         (a2),
        .fwd1_hit   (fwd1_hit),
        .fwd1_data  (fwd1_data),
        .fwd2_hit   (fwd2_hit),
        .fwd2_data  (fwd2_data),
        .count      (count),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    // Register file fed by the DUT write port.
    always @(posedge clk) begin
        if (we3) dut_rf[a3] <= wd3;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input logic [AW-1:0] a, output bit hit, output logic [XLEN-1:0] d);
        hit = 1'b0;
        d   = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (a != 0 && q[i].rd == a) begin
                hit = 1'b1;
                d   = q[i].data;
                break;
            end
        end
    endtask

    task automatic sample();
        bit              exp_ready;
        bit              h1, h2;
        logic [XLEN-1:0] d1, d2;
        @(negedge clk);
        exp_ready = !rst && (q.size() < DEPTH);
        exp_we    = !rst && (q.size() > 0) && !wport_busy;
        lookup(a1, h1, d1);
        lookup(a2, h2, d2);
        if (rst) begin
            h1 = 1'b0; d1 = '0; h2 = 1'b0; d2 = '0;
        end
        check("in_ready", 64'(in_ready), 64'(exp_ready));
        check("we3", 64'(we3), 64'(exp_we));
        check("a3", 64'(a3), exp_we ? 64'(q[0].rd) : 64'd0);
        check("wd3", 64'(wd3), exp_we ? 64'(q[0].data) : 64'd0);
        check("fwd1_hit", 64'(fwd1_hit), 64'(h1));
        check("fwd1_data", 64'(fwd1_data), 64'(d1));
        check("fwd2_hit", 64'(fwd2_hit), 64'(h2));
        check("fwd2_data", 64'(fwd2_data), 64'(d2));
        check("empty", 64'(empty), rst ? 64'd1 : 64'(q.size() == 0));
        if (!rst) check("count", 64'(count), 64'(q.size()));
        accepted = in_valid && exp_ready;
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (exp_we) begin
                rf_model[q[0].rd] = q[0].data;
                void'(q.pop_front());
            end
            if (accepted && in_rd != 0) q.push_back('{rd: in_rd, data: in_data});
        end
        last_acc = accepted;
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic drive(input bit v, input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
        in_valid = v;
        in_rd    = rd;
        in_data  = d;
    endtask

    logic [AW-1:0]   p_rd   [4] = '{5'd2, 5'd3, 5'd2, 5'd4};
    logic [XLEN-1:0] p_data [4] = '{32'h87654321, 32'hDEADBEEF, 32'h0000CAFE, 32'h00000001};

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf_model[i] = '0;
            dut_rf[i]   = '0;
        end
        rst = 1'b1; wport_busy = 1'b0; a1 = '0; a2 = '0;
        drive(1'b0, '0, '0);
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // Single write through an idle queue.
        drive(1'b1, 5'd1, 32'h12345678);
        a1 = 5'd1;
        cycle();
        drive(1'b0, '0, '0);
        sample();
        check("first_we3", 64'(we3), 64'd1);
        check("first_a3", 64'(a3), 64'd1);
        check("first_wd3", 64'(wd3), 64'h12345678);
        advance();
        sample();
        check("first_empty", 64'(empty), 64'd1);
        check("x1_written", 64'(dut_rf[1]), 64'h12345678);
        advance();

        // Fill while the write port is busy, then check forwarding and backpressure.
        wport_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, p_rd[i], p_data[i]);
            cycle();
        end
        drive(1'b1, 5'd7, 32'h77777777);
        a1 = 5'd2; a2 = 5'd5;
        sample();
        check("full_count", 64'(count), 64'd4);
        check("full_ready", 64'(in_ready), 64'd0);
        check("fwd1_newest", 64'(fwd1_data), 64'h0000CAFE);
        check("fwd2_miss", 64'(fwd2_hit), 64'd0);
        advance();
        cycle();
        wport_busy = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (last_acc) drive(1'b0, '0, '0);
            cycle();
        end
        check("x2_final", 64'(dut_rf[2]), 64'h0000CAFE);
        check("x3_final", 64'(dut_rf[3]), 64'hDEADBEEF);
        check("x7_final", 64'(dut_rf[7]), 64'h77777777);

        // Writes to x0 complete the handshake but are dropped.
        drive(1'b1, 5'd0, 32'hFFFFFFFF);
        a1 = 5'd0;
        sample();
        check("x0_ready", 64'(in_ready), 64'd1);
        advance();
        drive(1'b0, '0, '0);
        sample();
        check("x0_count", 64'(count), 64'd0);
        check("x0_we3", 64'(we3), 64'd0);
        check("x0_nohit", 64'(fwd1_hit), 64'd0);
        advance();

        // Back-to-back stream wraps the pointers.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, AW'(8 + i), 32'hA0000000 + i);
            a1 = AW'(8 + i); a2 = AW'(7 + i);
            sample();
            check("stream_ready", 64'(in_ready), 64'd1);
            check("stream_count_le1", 64'(count <= 1), 64'd1);
            advance();
        end
        drive(1'b0, '0, '0);
        cycle();
        cycle();
        check("stream_x8", 64'(dut_rf[8]), 64'hA0000000);
        check("stream_x17", 64'(dut_rf[17]), 64'hA0000009);

        // Reset with queued writes discards them.
        wport_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, AW'(20 + i), 32'h55550000 + i);
            cycle();
        end
        drive(1'b0, '0, '0);
        a1 = 5'd20; a2 = 5'd22;
        rst = 1'b1;
        sample();
        check("rst_we3", 64'(we3), 64'd0);
        check("rst_hit1", 64'(fwd1_hit), 64'd0);
        advance();
        rst = 1'b0;
        wport_busy = 1'b0;
        sample();
        check("post_rst_count", 64'(count), 64'd0);
        advance();
        cycle();
        cycle();
        check("x20_untouched", 64'(dut_rf[20]), 64'd0);
        check("x22_untouched", 64'(dut_rf[22]), 64'd0);

        // Randomized traffic against the model.
        last_acc = 1'b0;
        for (int n = 0; n < 600; n++) begin
            rst        = ($urandom_range(0, 79) == 0);
            wport_busy = ($urandom_range(0, 2) == 0);
            if (!in_valid || last_acc)
                drive($urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)), $urandom);
            a1 = AW'($urandom_range(0, 7));
            a2 = AW'($urandom_range(0, 7));
            cycle();
        end
        rst = 1'b0;
        wport_busy = 1'b0;
        drive(1'b0, '0, '0);
        for (int i = 0; i < DEPTH + 2; i++) cycle();
        for (int r = 0; r < 32; r++) check($sformatf("rf_x%0d", r), 64'(dut_rf[r]), 64'(rf_model[r]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
